// File: rtl/ltc2308_adc_responder.sv
`default_nettype none
// ============================================================================
// Module      : ltc2308_adc_responder
// Description : Device-side model of the LTC2308 4-wire serial ADC. Answers
//               CONVST/SCK/SDI from an ADC controller, returns 12-bit samples
//               taken from a parallel 8-channel bus on SDO.
// Revision    : 1.0 - initial release
// ============================================================================
module ltc2308_adc_responder #(
    parameter int         CONV_CYCLES = 80,
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] CFG_RESET   = 6'h22
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        adc_convst,
    input  logic        adc_sck,
    input  logic        adc_sdi,
    output logic        adc_sdo,
    input  logic [95:0] ch_data,
    output logic        busy,
    output logic [5:0]  cfg_word,
    output logic        cfg_valid
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        READY   = 2'd2,
        SHIFT   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] convst_sync, sck_sync, sdi_sync;
    logic                   convst_prev, sck_prev;
    logic                   convst_rise, sck_rise, sck_fall, sdi_bit;

    logic [CNT_W-1:0]       conv_cnt;
    logic [11:0]            result;
    logic [5:0]             active_cfg;
    logic [4:0]             cfg_shift;
    logic [2:0]             rise_cnt;
    logic [3:0]             fall_cnt;
    logic                   sdo;

    logic                   start_conv, latch, capture, shift_out;
    logic [2:0]             sel_ch;
    logic [11:0]            raw, sample;

    // Synchronise the asynchronous controller lines and keep one extra flop for edge detection
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            convst_sync <= '0;
            sck_sync    <= '0;
            sdi_sync    <= '0;
            convst_prev <= 1'b0;
            sck_prev    <= 1'b0;
        end else begin
            convst_sync <= {convst_sync[SYNC_STAGES-2:0], adc_convst};
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
            sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], adc_sdi};
            convst_prev <= convst_sync[SYNC_STAGES-1];
            sck_prev    <= sck_sync[SYNC_STAGES-1];
        end
    end

    // SDI travels through the same number of stages as SCK so the captured bit lines up with the rise
    assign convst_rise = convst_sync[SYNC_STAGES-1] & ~convst_prev;
    assign sck_rise    = sck_sync[SYNC_STAGES-1] & ~sck_prev;
    assign sck_fall    = ~sck_sync[SYNC_STAGES-1] & sck_prev;
    assign sdi_bit     = sdi_sync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a CONVST rise always takes priority over a coincident SCK edge
    always_comb begin
        state_next = state;
        start_conv = 1'b0;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (convst_rise) begin
                    state_next = CONVERT;
                    start_conv = 1'b1;
                end
            end
            CONVERT: begin
                if (conv_cnt == '0) begin
                    state_next = READY;
                    latch      = 1'b1;
                end
            end
            READY: begin
                if (convst_rise) begin
                    state_next = CONVERT;
                    start_conv = 1'b1;
                end else if (sck_rise) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (convst_rise) begin
                    state_next = CONVERT;
                    start_conv = 1'b1;
                end else if (sck_fall && fall_cnt == 4'd11) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame strobes: config bits on the first six rises, result bits on falls, only inside a frame
    assign capture   = sck_rise && !convst_rise && (state == READY || state == SHIFT)
                       && (rise_cnt < 3'd6);
    assign shift_out = sck_fall && !convst_rise && (state == SHIFT);
    assign busy      = (state == CONVERT);
    assign adc_sdo   = sdo;

    // Sample selection from the configuration captured at the conversion start
    always_comb begin
        sel_ch = {active_cfg[3], active_cfg[2], active_cfg[4]};
        raw    = ch_data[12*int'(sel_ch) +: 12];
        sample = active_cfg[1] ? raw : (raw ^ 12'h800);
        if (active_cfg[0]) begin
            sample = 12'h000;
        end
    end

    // Conversion timer, result latch, config capture and SDO shifting
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            conv_cnt   <= '0;
            result     <= '0;
            active_cfg <= CFG_RESET;
            cfg_word   <= CFG_RESET;
            cfg_shift  <= '0;
            cfg_valid  <= 1'b0;
            rise_cnt   <= '0;
            fall_cnt   <= '0;
            sdo        <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;

            if (start_conv) begin
                conv_cnt   <= CNT_W'(CONV_CYCLES - 1);
                active_cfg <= cfg_word;
                rise_cnt   <= '0;
                fall_cnt   <= '0;
                sdo        <= 1'b0;
            end else if (state == CONVERT && conv_cnt != '0) begin
                conv_cnt <= conv_cnt - 1'b1;
            end

            if (latch) begin
                result <= sample;
                sdo    <= sample[11];
            end

            if (capture) begin
                cfg_shift <= {cfg_shift[3:0], sdi_bit};
                rise_cnt  <= rise_cnt + 1'b1;
                if (rise_cnt == 3'd5) begin
                    cfg_word  <= {cfg_shift, sdi_bit};
                    cfg_valid <= 1'b1;
                end
            end

            if (shift_out) begin
                if (fall_cnt == 4'd11) begin
                    sdo      <= 1'b0;
                    fall_cnt <= '0;
                    rise_cnt <= '0;
                end else begin
                    sdo      <= result[4'd10 - fall_cnt];
                    fall_cnt <= fall_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ltc2308_adc_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ltc2308_adc_responder
// Description : Scoreboard bench for ltc2308_adc_responder. The driver acts
//               as the ADC controller; monitors rebuild SDO words and watch
//               cfg_valid, comparing against queued expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ltc2308_adc_responder;

    logic        clk_clk     = 1'b0;
    logic        reset_reset = 1'b1;
    logic        adc_convst  = 1'b0;
    logic        adc_sck     = 1'b0;
    logic        adc_sdi     = 1'b0;
    logic        adc_sdo;
    logic        busy;
    logic        cfg_valid;
    logic [5:0]  cfg_word;
    logic [95:0] ch_data;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic [5:0]  cfg_q[$];

    // Sweep: config selecting channel k+1 (k=7 wraps to ch0) and the result of the previous config
    logic [5:0]  sweep_cfg [8] = '{6'h32, 6'h26, 6'h36, 6'h2A, 6'h3A, 6'h2E, 6'h3E, 6'h22};
    logic [11:0] sweep_exp [8] = '{12'hA5C, 12'h123, 12'h2B7, 12'h3C1,
                                   12'h4D2, 12'h5E3, 12'h6F4, 12'h705};

    // 50 MHz system clock
    always #10 clk_clk = ~clk_clk;

    ltc2308_adc_responder #(
        .CONV_CYCLES(80),
        .SYNC_STAGES(2),
        .CFG_RESET  (6'h22)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .adc_convst (adc_convst),
        .adc_sck    (adc_sck),
        .adc_sdi    (adc_sdi),
        .adc_sdo    (adc_sdo),
        .ch_data    (ch_data),
        .busy       (busy),
        .cfg_word   (cfg_word),
        .cfg_valid  (cfg_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // SDO monitor: samples on each SCK rise like a controller; CONVST or reset discards a partial frame
    initial begin : sdo_monitor
        logic [11:0] word;
        int          nbits;
        word  = '0;
        nbits = 0;
        forever begin
            @(posedge adc_sck or posedge adc_convst or posedge reset_reset);
            if (adc_convst || reset_reset) begin
                nbits = 0;
            end else begin
                word = {word[10:0], adc_sdo};
                nbits++;
                if (nbits == 12) begin
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sdo_unexpected: got %h with no expected word", word);
                    end else begin
                        check("sdo_word", {20'h0, word}, {20'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // Config monitor: every cfg_valid cycle must match the next queued config word
    always @(negedge clk_clk) begin
        if (cfg_valid) begin
            if (cfg_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cfg_unexpected: got %h with no expected word", cfg_word);
            end else begin
                check("cfg_word_update", {26'h0, cfg_word}, {26'h0, cfg_q.pop_front()});
            end
        end
    end

    // Pulse CONVST, then measure how long busy stays high; optional second pulse mid-conversion
    task automatic start_conv(input bit mid, output int blen);
        int w;
        @(negedge clk_clk);
        adc_convst = 1'b1;
        repeat (2) @(negedge clk_clk);
        adc_convst = 1'b0;
        w = 0;
        while (!busy && w < 20) begin
            @(negedge clk_clk);
            w++;
        end
        blen = 0;
        while (busy && blen < 300) begin
            blen++;
            if (mid && blen == 20) adc_convst = 1'b1;
            if (mid && blen == 22) adc_convst = 1'b0;
            @(negedge clk_clk);
        end
        repeat (4) @(negedge clk_clk);
    endtask

    // Drive n SCK periods (8 clk low / 8 clk high) with the config word MSB-first on SDI
    task automatic shift(input logic [5:0] sdi_word, input logic [11:0] exp, input int n);
        if (n == 12) exp_q.push_back(exp);
        if (n >= 6)  cfg_q.push_back(sdi_word);
        for (int i = 0; i < n; i++) begin
            adc_sdi = (i < 6) ? sdi_word[5-i] : 1'b0;
            repeat (4) @(negedge clk_clk);
            adc_sck = 1'b1;
            repeat (8) @(negedge clk_clk);
            adc_sck = 1'b0;
            repeat (4) @(negedge clk_clk);
        end
        adc_sdi = 1'b0;
    endtask

    task automatic frame(input logic [5:0] sdi_word, input logic [11:0] exp);
        int blen;
        start_conv(1'b0, blen);
        check("busy_len", blen, 80);
        shift(sdi_word, exp, 12);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int blen;
        ch_data = {12'h705, 12'h6F4, 12'h5E3, 12'h4D2, 12'h3C1, 12'h2B7, 12'h123, 12'hA5C};

        // Reset state
        repeat (4) @(negedge clk_clk);
        check("reset_sdo", {31'h0, adc_sdo}, 0);
        check("reset_busy", {31'h0, busy}, 0);
        check("reset_cfg_word", {26'h0, cfg_word}, 32'h22);
        check("reset_cfg_valid", {31'h0, cfg_valid}, 0);
        reset_reset = 1'b0;
        repeat (4) @(negedge clk_clk);

        // Reset config reads ch0 unipolar; load ch1 unipolar for the next frame
        frame(6'h32, 12'hA5C);
        frame(6'h20, 12'h123);

        // ch0 bipolar of zero code, then sleep forces zero
        ch_data[11:0] = 12'h000;
        frame(6'h23, 12'h800);
        frame(6'h22, 12'h000);
        ch_data[11:0] = 12'hA5C;

        // Second CONVST during conversion is ignored
        start_conv(1'b1, blen);
        check("busy_len_mid_convst", blen, 80);
        // Abort after 5 SCKs: partial config discarded, new conversion proceeds
        shift(6'h3E, 12'h000, 5);
        start_conv(1'b0, blen);
        check("busy_len_abort", blen, 80);
        check("cfg_after_abort", {26'h0, cfg_word}, 32'h22);
        shift(6'h22, 12'hA5C, 12);

        // Channel sweep, each frame returns the channel chosen one frame earlier
        for (int k = 0; k < 8; k++) begin
            frame(sweep_cfg[k], sweep_exp[k]);
        end

        // Reset in the middle of a frame (active config selects ch5 = 12'h5E3)
        frame(6'h3A, 12'hA5C);
        start_conv(1'b0, blen);
        check("busy_len_pre_reset", blen, 80);
        shift(6'h00, 12'h000, 3);
        check("sdo_after_3_falls", {31'h0, adc_sdo}, 1);
        reset_reset = 1'b1;
        @(negedge clk_clk);
        check("midreset_sdo", {31'h0, adc_sdo}, 0);
        check("midreset_busy", {31'h0, busy}, 0);
        check("midreset_cfg_word", {26'h0, cfg_word}, 32'h22);
        check("midreset_cfg_valid", {31'h0, cfg_valid}, 0);
        reset_reset = 1'b0;
        repeat (4) @(negedge clk_clk);
        frame(6'h22, 12'hA5C);

        repeat (10) @(negedge clk_clk);
        check("sdo_queue_drained", exp_q.size(), 0);
        check("cfg_queue_drained", cfg_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
